// File: rtl/spi_mem_pkg.sv
// Shared types and constants for the SPI memory master.
// Optional build macro: SPI_FAST_READ_EN (fast-read opcode plus a dummy phase).
package spi_mem_pkg;

   localparam int CMD_W   = 8;
   localparam int DUMMY_W = 8;

   localparam logic [7:0] OP_READ      = 8'h03;
   localparam logic [7:0] OP_WRITE     = 8'h02;
   localparam logic [7:0] OP_FAST_READ = 8'h0B;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CMD   = 3'd1,
      ST_ADDR  = 3'd2,
      ST_DATA  = 3'd3,
      ST_DONE  = 3'd4
`ifdef SPI_FAST_READ_EN
      , ST_DUMMY = 3'd5
`endif
   } spi_state_t;

   // Opcode placed at the head of the frame for a read or write request.
   function automatic logic [7:0] opcode_for(input logic rwb);
      logic [7:0] op;
      if (rwb) begin
`ifdef SPI_FAST_READ_EN
         op = OP_FAST_READ;
`else
         op = OP_READ;
`endif
      end else begin
         op = OP_WRITE;
      end
      return op;
   endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK divider for the SPI memory master. sclk toggles every CLK_DIV clk
// cycles while enabled; rise_stb/fall_stb flag the clk edge at which sclk
// goes high/low. Disabling or resetting parks sclk low with the count cleared.
module spi_clk_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic resetb,
   input  logic en,
   output logic sclk,
   output logic rise_stb,
   output logic fall_stb
);

   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt;
   logic             tc;

   assign tc       = en & (cnt == CNT_MAX);
   assign rise_stb = tc & ~sclk;
   assign fall_stb = tc & sclk;

   // Half-period counter and SCLK toggle register.
   always_ff @(posedge clk) begin
      if (!resetb) begin
         cnt  <= '0;
         sclk <= 1'b0;
      end else if (!en) begin
         cnt  <= '0;
         sclk <= 1'b0;
      end else if (tc) begin
         cnt  <= '0;
         sclk <= ~sclk;
      end else begin
         cnt  <= cnt + CNT_W'(1);
         sclk <= sclk;
      end
   end

endmodule

// File: rtl/spi_mem_master.sv
// SPI (mode 0) master executing single-word memory reads and writes for the
// CPU control FSM. Frame = opcode + address + data, MSB first; halt_o stalls
// the FSM from the request cycle until the frame has finished.
// Optional build macro: SPI_FAST_READ_EN (reads use 0x0B and an 8-bit dummy phase).
module spi_mem_master
   import spi_mem_pkg::*;
#(
   parameter int CLK_DIV = 2,
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16
) (
   input  logic              clk,
   input  logic              resetb,
   input  logic              start_i,
   input  logic              rwb_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              rdata_valid_o,
   output logic              halt_o,
   output logic              sclk_o,
   output logic              cs_n_o,
   output logic              mosi_o,
   input  logic              miso_i
);

   localparam int FRAME_W = CMD_W + ADDR_W + DATA_W;
   localparam int MAX_PH  = (ADDR_W > DATA_W) ?
                            ((ADDR_W > CMD_W) ? ADDR_W : CMD_W) :
                            ((DATA_W > CMD_W) ? DATA_W : CMD_W);
   localparam int BC_W    = $clog2(MAX_PH + 1);

   spi_state_t        state;
   spi_state_t        next_state;
   logic              busy;
   logic              rwb_lat;
   // Frame bits still to be sent; the current bit lives in mosi_o itself.
   logic [FRAME_W-2:0] tx_shift;
   logic [DATA_W-1:0] rx_shift;
   logic [BC_W-1:0]   bit_cnt;
   logic [BC_W-1:0]   phase_end;
   logic              phase_last;
   logic              rise_stb;
   logic              fall_stb;

   spi_clk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_gen (
      .clk      (clk),
      .resetb   (resetb),
      .en       (busy),
      .sclk     (sclk_o),
      .rise_stb (rise_stb),
      .fall_stb (fall_stb)
   );

   // Shifting states keep the divider running; IDLE, DONE and unused codes do not.
   always_comb begin
      busy = 1'b0;
      case (state)
         ST_CMD, ST_ADDR, ST_DATA: busy = 1'b1;
`ifdef SPI_FAST_READ_EN
         ST_DUMMY:                 busy = 1'b1;
`endif
         default:                  busy = 1'b0;
      endcase
   end

   // Index of the last bit of the current phase.
   always_comb begin
      phase_end = '0;
      case (state)
         ST_CMD:   phase_end = BC_W'(CMD_W - 1);
         ST_ADDR:  phase_end = BC_W'(ADDR_W - 1);
         ST_DATA:  phase_end = BC_W'(DATA_W - 1);
`ifdef SPI_FAST_READ_EN
         ST_DUMMY: phase_end = BC_W'(DUMMY_W - 1);
`endif
         default:  phase_end = '0;
      endcase
   end

   assign phase_last = (bit_cnt == phase_end);

   // State register.
   always_ff @(posedge clk) begin
      if (!resetb) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode and the stall request; phases advance on the falling
   // strobe of their last bit. The IDLE term of halt_o is combinational so the
   // FSM is held in the very cycle it raises start_i.
   always_comb begin
      next_state = state;
      halt_o     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start_i) begin
               next_state = ST_CMD;
            end else begin
               next_state = ST_IDLE;
            end
         end
         ST_CMD: begin
            if (fall_stb && phase_last) begin
               next_state = ST_ADDR;
            end else begin
               next_state = ST_CMD;
            end
         end
         ST_ADDR: begin
            if (fall_stb && phase_last) begin
`ifdef SPI_FAST_READ_EN
               if (rwb_lat) begin
                  next_state = ST_DUMMY;
               end else begin
                  next_state = ST_DATA;
               end
`else
               next_state = ST_DATA;
`endif
            end else begin
               next_state = ST_ADDR;
            end
         end
`ifdef SPI_FAST_READ_EN
         ST_DUMMY: begin
            if (fall_stb && phase_last) begin
               next_state = ST_DATA;
            end else begin
               next_state = ST_DUMMY;
            end
         end
`endif
         ST_DATA: begin
            if (fall_stb && phase_last) begin
               next_state = ST_DONE;
            end else begin
               next_state = ST_DATA;
            end
         end
         ST_DONE: next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase

      if (resetb && (((state == ST_IDLE) && start_i) || busy)) begin
         halt_o = 1'b1;
      end else begin
         halt_o = 1'b0;
      end
   end

   // Frame datapath: accept/latch, shift out on falling strobes, sample on
   // rising strobes, and hand the read word back on entry to DONE.
   always_ff @(posedge clk) begin
      if (!resetb) begin
         cs_n_o        <= 1'b1;
         mosi_o        <= 1'b0;
         rdata_o       <= '0;
         rdata_valid_o <= 1'b0;
         rwb_lat       <= 1'b0;
         tx_shift      <= '0;
         rx_shift      <= '0;
         bit_cnt       <= '0;
      end else begin
         rdata_valid_o <= 1'b0;
         if (state == ST_IDLE) begin
            if (start_i) begin
               rwb_lat  <= rwb_i;
               // Reads send zeros in the data phase.
               {mosi_o, tx_shift} <= {opcode_for(rwb_i), addr_i,
                                      (rwb_i ? {DATA_W{1'b0}} : wdata_i)};
               cs_n_o   <= 1'b0;
               bit_cnt  <= '0;
            end else begin
               cs_n_o <= 1'b1;
               mosi_o <= 1'b0;
            end
         end else if (busy) begin
            if (rise_stb && rwb_lat && (state == ST_DATA)) begin
               rx_shift <= {rx_shift[DATA_W-2:0], miso_i};
            end
            if (fall_stb) begin
               if (phase_last) begin
                  bit_cnt <= '0;
               end else begin
                  bit_cnt <= bit_cnt + BC_W'(1);
               end
               if (next_state == ST_DONE) begin
                  cs_n_o <= 1'b1;
                  mosi_o <= 1'b0;
                  if (rwb_lat) begin
                     rdata_o       <= rx_shift;
                     rdata_valid_o <= 1'b1;
                  end
               end
`ifdef SPI_FAST_READ_EN
               // Dummy bits drive zero and hold back the pending data bit.
               else if (next_state == ST_DUMMY) begin
                  mosi_o <= 1'b0;
               end
`endif
               else begin
                  mosi_o   <= tx_shift[FRAME_W-2];
                  tx_shift <= {tx_shift[FRAME_W-3:0], 1'b0};
               end
            end
         end else begin
            cs_n_o <= 1'b1;
            mosi_o <= 1'b0;
         end
      end
   end

endmodule

// File: doc/spi_mem_master.md
Name: spi_mem_master

Overview:
- SPI master that executes the memory transactions requested by the CPU control FSM.
- Sits directly downstream of the control FSM: it consumes the FSM's start, read/write-bar and the selected address/write data, and drives the external SPI memory pins.
- Returns read data to the datapath and holds the FSM via halt_o while a transaction is in flight.

Parameters:
- CLK_DIV, 2, number of clk cycles per SCLK half-period; legal range >= 1.
- ADDR_W, 16, width of the address field sent on the wire.
- DATA_W, 16, data word width.

Ports:
- clk  input  1  system clock.
- resetb  input  1  synchronous active-low reset.
- start_i  input  1  transaction request (level); sampled only in IDLE.
- rwb_i  input  1  1 = read, 0 = write; latched at accept.
- addr_i  input  ADDR_W  memory address; latched at accept.
- wdata_i  input  DATA_W  write data; latched at accept.
- rdata_o  output  DATA_W  last read word.
- rdata_valid_o  output  1  one-cycle pulse when rdata_o updates.
- halt_o  output  1  stall request to the control FSM.
- sclk_o  output  1  SPI clock, mode 0 (idle low).
- cs_n_o  output  1  chip select, active low.
- mosi_o  output  1  serial data out, MSB first.
- miso_i  input  1  serial data in.

Behaviour:
- Reset (resetb low at a clk edge):
  - state = IDLE, cs_n_o = 1, sclk_o = 0, mosi_o = 0, rdata_o = 0, rdata_valid_o = 0.
  - halt_o is gated by resetb, so it is 0 while resetb is low.
  - Applying reset mid-transaction aborts it at that edge. No partial rdata_o update and no valid pulse.
- States: IDLE, CMD, ADDR, DATA, DONE (plus DUMMY when the optional feature is compiled in).
- halt_o = resetb & ((state == IDLE & start_i) | (state not in {IDLE, DONE})).
  - The IDLE term is combinational so the FSM cannot advance in the cycle it raises start.
- Accept (IDLE & start_i at an edge):
  - Latch rwb, addr and wdata.
  - Frame = opcode(8) + addr(ADDR_W) + data(DATA_W). Opcode is 0x03 for read, 0x02 for write.
  - cs_n_o goes to 0 and mosi_o takes the frame MSB. Next state is CMD.
- Divider: a counter counts 0..CLK_DIV-1 and toggles sclk_o at terminal count.
  - Rising SCLK edge: a strobe samples miso_i.
  - Falling SCLK edge: a strobe shifts the next bit onto mosi_o.
- Phase progression:
  - CMD -> ADDR after 8 bits.
  - ADDR -> DATA after ADDR_W bits.
  - DATA -> DONE after DATA_W bits; phase changes happen on the falling-edge strobe of each phase's last bit.
- Read vs write:
  - Read: mosi_o = 0 during DATA; miso_i is shifted into the receive register on rising strobes.
  - Write: wdata is shifted out; miso_i is ignored.
- Frame timing: with N = 8 + ADDR_W + DATA_W, the shifting states last 2*N*CLK_DIV cycles.
  - halt_o is high for 1 + 2*N*CLK_DIV cycles (161 at defaults).
- DONE (lasts 1 cycle):
  - cs_n_o = 1, sclk_o = 0, halt_o = 0.
  - Read: rdata_o is loaded and rdata_valid_o pulses. Write: rdata_o holds its value.
  - start_i is ignored in DONE. Next state is IDLE, so a still-high start_i is accepted the following cycle (back-to-back gap of 1 cycle).
- Input stability: changes to rwb_i, addr_i or wdata_i after accept have no effect.
- Unused states decode to IDLE.

Optional Feature:
- Macro: SPI_FAST_READ_EN.
- Defined: reads use opcode 0x0B and insert a DUMMY state of 8 SCLK cycles (mosi_o = 0, miso_i ignored) between ADDR and DATA. Read halt at defaults becomes 193 cycles.
- Undefined: DUMMY state and opcode 0x0B are not compiled.
- Writes are identical in both cases.

Decomposition:
- Package spi_mem_pkg: spi_state_t enum; opcode constants OP_READ = 8'h03, OP_WRITE = 8'h02, OP_FAST_READ = 8'h0B; CMD_W = 8; DUMMY_W = 8.
- Sub-module spi_clk_gen: divider producing sclk_o, rise_stb and fall_stb. Enabled while busy; clears to sclk = 0 on reset or disable.

Test Plan:
- Read, addr 0x0012, miso model returns 0xBEEF, CLK_DIV = 2 -> MOSI bits 0x03 then 0x0012; halt_o high for exactly 161 cycles; rdata_o = 0xBEEF with a single rdata_valid_o pulse in DONE; cs_n_o low for 160 cycles.
- Write, addr 0x7FFF, wdata 0xA5A5 -> MOSI stream 0x02_7FFF_A5A5; rdata_valid_o never asserts; rdata_o unchanged.
- start_i held high across DONE with rwb toggled to 0 -> exactly one cycle of halt_o = 0 between transactions; the second frame starts with opcode 0x02.
- resetb driven low at cycle 50 of a read -> at the next edge cs_n_o = 1, sclk_o = 0, state IDLE, no valid pulse; the transaction restarts cleanly after release.
- CLK_DIV = 1 read -> halt_o high for 81 cycles; sclk_o toggles every clk; data correct.
- SPI_FAST_READ_EN defined, read -> opcode 0x0B, 8 dummy SCLK cycles, halt_o high for 193 cycles; write timing unchanged at 161 cycles.
